// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared definitions for the forwarding/hazard unit: address width, forward-select
// encoding and the long-latency scoreboard entry layout.
package forwarding_hazard_unit_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int FWD_RF     = 0;
    // Wide enough for any latency field up to 16 bits.
    localparam int SB_CNT_W   = 16;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [SB_CNT_W-1:0]   cnt;
    } sb_entry_t;

    localparam sb_entry_t SB_ENTRY_RST = '{valid: 1'b0, addr: '0, cnt: '0};

    function automatic logic addr_match(input logic [REG_ADDR_W-1:0] a,
                                        input logic [REG_ADDR_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

endpackage

// File: rtl/forwarding_hazard_unit_fwd_src_select.sv
// Per-source forwarding priority match: the nearest writing stage whose
// nonzero destination equals this source operand wins.
module fwd_src_select
    import forwarding_hazard_unit_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int SEL_W   = 2
) (
    input  logic [REG_ADDR_W-1:0]         src_addr_i,
    input  logic [NUM_FWD-1:0]            stg_wr_en_i,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] stg_wr_addr_i,
    output logic [SEL_W-1:0]              sel_o
);

    // Walk oldest to nearest so the lowest matching index overrides.
    always_comb begin
        sel_o = SEL_W'(FWD_RF);
        for (int j = NUM_FWD - 1; j >= 0; j--) begin
            sel_o = (stg_wr_en_i[j] &&
                     addr_match(stg_wr_addr_i[j*REG_ADDR_W +: REG_ADDR_W], src_addr_i))
                    ? SEL_W'(j + 1) : sel_o;
        end
    end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding, load-use and long-latency scoreboard hazard detection.
// Optional stall statistics counters are built when FWD_HAZARD_STATS_EN is defined.
module forwarding_hazard_unit
    import forwarding_hazard_unit_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int NUM_FWD  = 2,
    parameter int SB_DEPTH = 4,
    parameter int LAT_W    = 4,
    localparam int SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_src_addr,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
    input  logic [NUM_FWD-1:0]            stg_wr_en,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] stg_wr_addr,
    input  logic                          ex_mem_read,
    input  logic [REG_ADDR_W-1:0]         ex_wr_addr,
    input  logic                          issue_long,
    input  logic [REG_ADDR_W-1:0]         issue_addr,
    input  logic [LAT_W-1:0]              issue_lat,
    input  logic                          flush,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    output logic                          stall,
    output logic                          sb_full,
    output logic [31:0]                   stall_cycles,
    output logic [31:0]                   load_use_cnt
);

    sb_entry_t             sb_q [SB_DEPTH];
    sb_entry_t             sb_d [SB_DEPTH];
    logic [SB_DEPTH-1:0]   valid_s;
    logic                  load_use_s;
    logic                  sb_hit_s;
    logic                  accept_s;
    logic                  alloc_done_s;
    logic [SB_CNT_W-1:0]   lat_s;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_src_select #(
            .NUM_FWD (NUM_FWD),
            .SEL_W   (SEL_W)
        ) u_sel (
            .src_addr_i    (ex_src_addr[g*REG_ADDR_W +: REG_ADDR_W]),
            .stg_wr_en_i   (stg_wr_en),
            .stg_wr_addr_i (stg_wr_addr),
            .sel_o         (fwd_sel[g*SEL_W +: SEL_W])
        );
    end

    // Hazard detection against the ID-stage operands.
    always_comb begin
        load_use_s = 1'b0;
        sb_hit_s   = 1'b0;
        for (int e = 0; e < SB_DEPTH; e++) begin
            valid_s[e] = sb_q[e].valid;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            load_use_s = load_use_s | (ex_mem_read &&
                         addr_match(ex_wr_addr, id_src_addr[i*REG_ADDR_W +: REG_ADDR_W]));
            for (int e = 0; e < SB_DEPTH; e++) begin
                sb_hit_s = sb_hit_s | (sb_q[e].valid &&
                           addr_match(sb_q[e].addr, id_src_addr[i*REG_ADDR_W +: REG_ADDR_W]));
            end
        end
    end

    assign sb_full  = &valid_s;
    assign stall    = load_use_s | sb_hit_s | (issue_long & sb_full);
    assign accept_s = issue_long & ~stall & ~flush;
    assign lat_s    = (issue_lat == '0) ? SB_CNT_W'(1) : SB_CNT_W'(issue_lat);

    // Scoreboard next state: age valid entries, allocate only into slots already free.
    always_comb begin
        alloc_done_s = 1'b0;
        for (int e = 0; e < SB_DEPTH; e++) begin
            sb_d[e] = sb_q[e];
            if (sb_q[e].valid) begin
                if (sb_q[e].cnt == SB_CNT_W'(1)) begin
                    sb_d[e] = SB_ENTRY_RST;
                end else begin
                    sb_d[e].cnt = sb_q[e].cnt - SB_CNT_W'(1);
                end
            end else if (accept_s && !alloc_done_s) begin
                sb_d[e].valid = 1'b1;
                sb_d[e].addr  = issue_addr;
                sb_d[e].cnt   = lat_s;
                alloc_done_s  = 1'b1;
            end else begin
                sb_d[e] = sb_q[e];
            end
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk) begin
        for (int e = 0; e < SB_DEPTH; e++) begin
            if (!reset) begin
                sb_q[e] <= SB_ENTRY_RST;
            end else begin
                sb_q[e] <= sb_d[e];
            end
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] load_use_cnt_q;

    // Saturating stall and load-use event counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles_q <= 32'd0;
            load_use_cnt_q <= 32'd0;
        end else begin
            if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (load_use_s && (load_use_cnt_q != 32'hFFFF_FFFF)) begin
                load_use_cnt_q <= load_use_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign load_use_cnt = load_use_cnt_q;
`else
    assign stall_cycles = 32'd0;
    assign load_use_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit: combinational vector table plus
// scoreboard, reset and statistics sequences.
module tb_forwarding_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  ex_src_addr;
    logic [9:0]  id_src_addr;
    logic [1:0]  stg_wr_en;
    logic [9:0]  stg_wr_addr;
    logic        ex_mem_read;
    logic [4:0]  ex_wr_addr;
    logic        issue_long;
    logic [4:0]  issue_addr;
    logic [3:0]  issue_lat;
    logic        flush;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic        sb_full;
    logic [31:0] stall_cycles;
    logic [31:0] load_use_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    forwarding_hazard_unit dut (
        .clk          (clk),
        .reset        (reset),
        .ex_src_addr  (ex_src_addr),
        .id_src_addr  (id_src_addr),
        .stg_wr_en    (stg_wr_en),
        .stg_wr_addr  (stg_wr_addr),
        .ex_mem_read  (ex_mem_read),
        .ex_wr_addr   (ex_wr_addr),
        .issue_long   (issue_long),
        .issue_addr   (issue_addr),
        .issue_lat    (issue_lat),
        .flush        (flush),
        .fwd_sel      (fwd_sel),
        .stall        (stall),
        .sb_full      (sb_full),
        .stall_cycles (stall_cycles),
        .load_use_cnt (load_use_cnt)
    );

    typedef struct {
        logic [4:0] ex0, ex1, id0, id1;
        logic [1:0] en;
        logic [4:0] a0, a1;
        logic       mr;
        logic [4:0] exw;
        logic [1:0] s0, s1;
        logic       st;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_id(input logic [4:0] i0, input logic [4:0] i1);
        id_src_addr = {i1, i0};
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        // ex0 ex1 id0 id1 en a0 a1 mr exw s0 s1 st
        vecs[0] = '{5'd5, 5'd0, 5'd0, 5'd0, 2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 2'd1, 2'd0, 1'b0};
        vecs[1] = '{5'd0, 5'd3, 5'd0, 5'd0, 2'b10, 5'd3, 5'd0, 1'b0, 5'd0, 2'd0, 2'd0, 1'b0};
        vecs[2] = '{5'd7, 5'd7, 5'd0, 5'd0, 2'b10, 5'd1, 5'd7, 1'b0, 5'd0, 2'd2, 2'd2, 1'b0};
        vecs[3] = '{5'd4, 5'd9, 5'd0, 5'd0, 2'b11, 5'd9, 5'd4, 1'b0, 5'd0, 2'd2, 2'd1, 1'b0};
        vecs[4] = '{5'd6, 5'd2, 5'd0, 5'd0, 2'b01, 5'd6, 5'd6, 1'b0, 5'd0, 2'd1, 2'd0, 1'b0};
        vecs[5] = '{5'd0, 5'd0, 5'd1, 5'd8, 2'b00, 5'd0, 5'd0, 1'b1, 5'd8, 2'd0, 2'd0, 1'b1};
        vecs[6] = '{5'd0, 5'd0, 5'd1, 5'd8, 2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 2'd0, 2'd0, 1'b0};
        vecs[7] = '{5'd0, 5'd0, 5'd8, 5'd2, 2'b00, 5'd0, 5'd0, 1'b1, 5'd8, 2'd0, 2'd0, 1'b1};
        vecs[8] = '{5'd0, 5'd0, 5'd8, 5'd2, 2'b00, 5'd0, 5'd0, 1'b0, 5'd8, 2'd0, 2'd0, 1'b0};
        vecs[9] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 2'd0, 2'd0, 1'b0};

        reset       = 1'b0;
        ex_src_addr = '0;
        id_src_addr = '0;
        stg_wr_en   = '0;
        stg_wr_addr = '0;
        ex_mem_read = 1'b0;
        ex_wr_addr  = '0;
        issue_long  = 1'b0;
        issue_addr  = '0;
        issue_lat   = '0;
        flush       = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_sb_full", 32'(sb_full), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_stall_cycles", stall_cycles, 32'd0);
        chk("rst_load_use_cnt", load_use_cnt, 32'd0);

        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            ex_src_addr = {vecs[v].ex1, vecs[v].ex0};
            id_src_addr = {vecs[v].id1, vecs[v].id0};
            stg_wr_en   = vecs[v].en;
            stg_wr_addr = {vecs[v].a1, vecs[v].a0};
            ex_mem_read = vecs[v].mr;
            ex_wr_addr  = vecs[v].exw;
            #1;
            chk($sformatf("vec%0d_sel0", v), 32'(fwd_sel[1:0]), 32'(vecs[v].s0));
            chk($sformatf("vec%0d_sel1", v), 32'(fwd_sel[3:2]), 32'(vecs[v].s1));
            chk($sformatf("vec%0d_stall", v), 32'(stall), 32'(vecs[v].st));
        end

        @(negedge clk);
        ex_mem_read = 1'b0;
        ex_wr_addr  = '0;
        stg_wr_en   = '0;
        set_id(5'd0, 5'd0);
        pulse_reset();

        // Long op to r12, latency 3: exactly three stall cycles once it is read.
        issue_long = 1'b1; issue_addr = 5'd12; issue_lat = 4'd3;
        #1;
        chk("issue12_pre_stall", 32'(stall), 32'd0);
        @(negedge clk);
        issue_long = 1'b0;
        set_id(5'd12, 5'd0);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("lat3_cycle%0d", c), 32'(stall), (c < 3) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

        // Zero latency is treated as one cycle.
        set_id(5'd0, 5'd0);
        issue_long = 1'b1; issue_addr = 5'd13; issue_lat = 4'd0;
        @(negedge clk);
        issue_long = 1'b0;
        set_id(5'd0, 5'd13);
        #1;
        chk("lat0_cycle0", 32'(stall), 32'd1);
        @(negedge clk);
        #1;
        chk("lat0_cycle1", 32'(stall), 32'd0);

        // Flush blocks acceptance.
        set_id(5'd0, 5'd0);
        issue_long = 1'b1; issue_addr = 5'd14; issue_lat = 4'd5; flush = 1'b1;
        @(negedge clk);
        issue_long = 1'b0; flush = 1'b0;
        set_id(5'd14, 5'd0);
        #1;
        chk("flush_no_alloc", 32'(stall), 32'd0);

        // Fill all entries with long latency, including a duplicate address.
        set_id(5'd0, 5'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            issue_long = 1'b1; issue_addr = (k == 3) ? 5'd21 : 5'(20 + k); issue_lat = 4'd15;
        end
        @(negedge clk);
        issue_addr = 5'd24;
        #1;
        chk("full_sb_full", 32'(sb_full), 32'd1);
        chk("full_issue_stall", 32'(stall), 32'd1);
        @(negedge clk);
        issue_long = 1'b0;
        set_id(5'd24, 5'd0);
        #1;
        chk("full_no_alloc", 32'(stall), 32'd0);
        set_id(5'd0, 5'd21);
        #1;
        chk("dup_hit_stall", 32'(stall), 32'd1);
        pulse_reset();
        #1;
        chk("reset_clears_full", 32'(sb_full), 32'd0);
        chk("reset_releases_stall", 32'(stall), 32'd0);

        // A slot freed at an edge is only reused on the following edge.
        set_id(5'd0, 5'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            issue_long = 1'b1; issue_addr = 5'(20 + k); issue_lat = (k == 0) ? 4'd4 : 4'd15;
        end
        @(negedge clk);
        issue_addr = 5'd25;
        #1;
        chk("reuse_full_stall", 32'(stall), 32'd1);
        @(negedge clk);
        #1;
        chk("reuse_freed", 32'(sb_full), 32'd0);
        chk("reuse_accept_ok", 32'(stall), 32'd0);
        @(negedge clk);
        issue_long = 1'b0;
        set_id(5'd25, 5'd0);
        #1;
        chk("reuse_full_again", 32'(sb_full), 32'd1);
        chk("reuse_hit", 32'(stall), 32'd1);

        // Statistics: five cycles of load-use stall after a clean reset.
        set_id(5'd0, 5'd0);
        pulse_reset();
        ex_mem_read = 1'b1; ex_wr_addr = 5'd8; set_id(5'd0, 5'd8);
        repeat (5) @(posedge clk);
        @(negedge clk);
        ex_mem_read = 1'b0; ex_wr_addr = '0; set_id(5'd0, 5'd0);
        #1;
`ifdef FWD_HAZARD_STATS_EN
        chk("stats_stall_cycles", stall_cycles, 32'd5);
        chk("stats_load_use_cnt", load_use_cnt, 32'd5);
`else
        chk("stats_stall_cycles", stall_cycles, 32'd0);
        chk("stats_load_use_cnt", load_use_cnt, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/forwarding_hazard_unit.md
FORWARDING_HAZARD_UNIT -- requirements
Module: forwarding_hazard_unit

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, meaning source operands per instruction.
REQ-002 SHALL have parameter NUM_FWD, default 2, meaning forwarding stages; index 0 is nearest (EX/MEM), index NUM_FWD-1 is oldest.
REQ-003 SHALL have parameter SB_DEPTH, default 4, meaning scoreboard entries for long-latency writes.
REQ-004 SHALL have parameter LAT_W, default 4, meaning latency field width.
REQ-005 SHALL have ports: clk in 1, single clock; reset in 1, synchronous, active-low.
REQ-006 SHALL have ports: ex_src_addr in NUM_SRC*5, EX-stage source registers; id_src_addr in NUM_SRC*5, ID-stage source registers.
REQ-007 SHALL have ports: stg_wr_en in NUM_FWD, stage writes register; stg_wr_addr in NUM_FWD*5, stage destination.
REQ-008 SHALL have ports: ex_mem_read in 1, load in EX; ex_wr_addr in 5, EX destination.
REQ-009 SHALL have ports: issue_long in 1, long op in ID; issue_addr in 5; issue_lat in LAT_W; flush in 1.
REQ-010 SHALL have ports: fwd_sel out NUM_SRC*SEL_W, SEL_W=$clog2(NUM_FWD+1); stall out 1; sb_full out 1; stall_cycles out 32; load_use_cnt out 32.

Function
REQ-011 fwd_sel[i] SHALL be combinational: 0 selects register file, k selects stage k-1.
REQ-012 fwd_sel[i] SHALL select the lowest stage index j where stg_wr_en[j] is high, stg_wr_addr[j]!=0 and stg_wr_addr[j]==ex_src_addr[i].
REQ-013 Register 0 SHALL never forward.
REQ-014 Load-use hazard SHALL be: ex_mem_read high, ex_wr_addr!=0, and ex_wr_addr equal to any id_src_addr.
REQ-015 Scoreboard hit SHALL be any valid entry whose addr is nonzero and equals any id_src_addr.
REQ-016 stall SHALL equal load-use OR scoreboard hit OR (issue_long AND sb_full); it SHALL be combinational from inputs and registered state.
REQ-017 sb_full SHALL be high when all SB_DEPTH entries are valid, computed from registered state only.
REQ-018 An issue SHALL be accepted at a clock edge when issue_long=1, stall=0 and flush=0; it allocates the lowest-index free entry {valid=1, addr=issue_addr, cnt=max(issue_lat,1)}.
REQ-019 Each valid entry SHALL decrement cnt every cycle; an entry with cnt==1 SHALL become invalid at that edge.
REQ-020 A slot freed at an edge SHALL become allocatable only from the following cycle.
REQ-021 Duplicate addr entries SHALL be permitted; a hit on any of them stalls.
REQ-022 flush SHALL block acceptance only; it SHALL NOT clear existing entries.

Reset
REQ-023 When reset=0 at a clk edge: all entries invalid, cnt=0, stall_cycles=0, load_use_cnt=0.
REQ-024 Reset mid-operation SHALL discard pending entries and release stall in the first cycle after reset deasserts unless a load-use hazard exists.

Configuration
REQ-025 Macro FWD_HAZARD_STATS_EN defined: stall_cycles SHALL increment (saturating at 2^32-1) each cycle stall=1; load_use_cnt SHALL increment (saturating) each cycle a load-use hazard is present.
REQ-026 Macro FWD_HAZARD_STATS_EN undefined: stall_cycles and load_use_cnt SHALL be constant 0 and no counter registers SHALL be built.

Structure
REQ-027 A shared package SHALL hold REG_ADDR_W=5, the fwd_sel encoding constants (FWD_RF=0) and the scoreboard entry struct {valid, addr, cnt}.
REQ-028 A single sub-module fwd_src_select SHALL implement the per-source priority match, instantiated NUM_SRC times.

Verification
REQ-029 stg_wr_en=2'b11, stg_wr_addr={5,5}, ex_src_addr[0]=5 -> fwd_sel[0]=1, meaning nearest stage wins.
REQ-030 stg_wr_en=2'b10, stg_wr_addr[1]=0, ex_src_addr[0]=0 -> fwd_sel[0]=0.
REQ-031 ex_mem_read=1, ex_wr_addr=8, id_src_addr[1]=8 -> stall=1; with ex_wr_addr=0 -> stall=0.
REQ-032 issue_long=1, issue_addr=12, issue_lat=3 accepted; next cycle id_src_addr[0]=12 -> stall=1 for exactly 3 cycles, then 0.
REQ-033 Fill SB_DEPTH=4 entries with lat=15, then issue_long=1 -> sb_full=1, stall=1, no allocation; assert reset=0 for one cycle -> sb_full=0 next cycle.
REQ-034 With stats enabled, 5 cycles of load-use stall -> stall_cycles=5 and load_use_cnt=5; with the macro undefined -> both read 0.
